// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST stimulus source: FSM states,
// the uniform weight/activation pattern table and partial-sum sizing.
package bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    WAIT,
    CHECK,
    DONE
  } state_t;

  localparam int NUM_BASE_PATTERNS = 4;

  localparam logic [7:0] PATTERN_W [NUM_BASE_PATTERNS] = '{8'hFF, 8'h55, 8'h0F, 8'h01};
  localparam logic [7:0] PATTERN_A [NUM_BASE_PATTERNS] = '{8'hFF, 8'hAA, 8'hF0, 8'h01};

  // Width of one column's dot product: product bits plus growth from summing size terms.
  function automatic int psum_width(input int weight_width, input int act_width, input int size);
    return weight_width + act_width + $clog2(size);
  endfunction

endpackage

// File: rtl/test_pattern_rom.sv
// Combinational pattern lookup: pattern index to uniform weight, activation
// and the golden column partial sum SYSTOLIC_SIZE * W * A.
module test_pattern_rom
  import bist_pkg::*;
#(
  parameter int SYSTOLIC_SIZE     = 8,
  parameter int WEIGHT_WIDTH      = 8,
  parameter int ACTIVATION_WIDTH  = 8,
  parameter int PARTIAL_SUM_WIDTH = psum_width(WEIGHT_WIDTH, ACTIVATION_WIDTH, SYSTOLIC_SIZE)
) (
  input  logic [1:0]                   pattern_idx,
  output logic [WEIGHT_WIDTH-1:0]      weight,
  output logic [ACTIVATION_WIDTH-1:0]  act,
  output logic [PARTIAL_SUM_WIDTH-1:0] golden
);

  always_comb begin
    weight = WEIGHT_WIDTH'(PATTERN_W[pattern_idx]);
    act    = ACTIVATION_WIDTH'(PATTERN_A[pattern_idx]);
    golden = PARTIAL_SUM_WIDTH'(SYSTOLIC_SIZE) * PARTIAL_SUM_WIDTH'(weight)
           * PARTIAL_SUM_WIDTH'(act);
  end

endmodule

// File: rtl/bist_pattern_gen.sv
// BIST stimulus source for the systolic array: streams uniform patterns,
// presents golden sums with a compare strobe, and builds a sticky fault map.
module bist_pattern_gen
  import bist_pkg::*;
#(
  parameter int SYSTOLIC_SIZE     = 8,
  parameter int WEIGHT_WIDTH      = 8,
  parameter int ACTIVATION_WIDTH  = 8,
  parameter int PARTIAL_SUM_WIDTH = psum_width(WEIGHT_WIDTH, ACTIVATION_WIDTH, SYSTOLIC_SIZE),
  parameter int NUM_PATTERNS      = 4,
  parameter int ARRAY_LATENCY     = 2 * SYSTOLIC_SIZE
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  output logic                                     weight_load,
  output logic [WEIGHT_WIDTH*SYSTOLIC_SIZE-1:0]    weight_flat,
  output logic                                     act_valid,
  output logic [ACTIVATION_WIDTH*SYSTOLIC_SIZE-1:0] act_flat,
  output logic [PARTIAL_SUM_WIDTH-1:0]             correct_answer,
  output logic                                     compare_valid,
  input  logic [SYSTOLIC_SIZE-1:0]                 compared_results,
  output logic [SYSTOLIC_SIZE-1:0]                 fault_map,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     pass
);

  localparam int PW      = (NUM_PATTERNS > 4) ? $clog2(NUM_PATTERNS) : 2;
  localparam int MAX_LEN = (ARRAY_LATENCY > SYSTOLIC_SIZE) ? ARRAY_LATENCY : SYSTOLIC_SIZE;
  localparam int CW      = $clog2(MAX_LEN + 1);

  localparam logic [CW-1:0] LAST_SIZE = CW'(SYSTOLIC_SIZE - 1);
  localparam logic [CW-1:0] LAST_LAT  = CW'(ARRAY_LATENCY - 1);
  localparam logic [PW-1:0] LAST_PAT  = PW'(NUM_PATTERNS - 1);

  state_t                        state, state_n;
  logic [CW-1:0]                 cnt;
  logic [PW-1:0]                 pat;
  logic [WEIGHT_WIDTH-1:0]       rom_weight;
  logic [ACTIVATION_WIDTH-1:0]   rom_act;
  logic [PARTIAL_SUM_WIDTH-1:0]  rom_golden;
  logic [SYSTOLIC_SIZE-1:0]      fault_map_n;

  // Only the low two index bits select a table entry, so longer tests wrap.
  test_pattern_rom #(
    .SYSTOLIC_SIZE     (SYSTOLIC_SIZE),
    .WEIGHT_WIDTH      (WEIGHT_WIDTH),
    .ACTIVATION_WIDTH  (ACTIVATION_WIDTH),
    .PARTIAL_SUM_WIDTH (PARTIAL_SUM_WIDTH)
  ) u_rom (
    .pattern_idx (pat[1:0]),
    .weight      (rom_weight),
    .act         (rom_act),
    .golden      (rom_golden)
  );

  always_comb begin
    state_n       = state;
    weight_load   = 1'b0;
    act_valid     = 1'b0;
    compare_valid = 1'b0;
    done          = 1'b0;
    busy          = (state != IDLE);
    case (state)
      IDLE:   if (start) state_n = LOAD_W;
      LOAD_W: begin
        weight_load = 1'b1;
        if (cnt == LAST_SIZE) state_n = STREAM;
      end
      STREAM: begin
        act_valid = 1'b1;
        if (cnt == LAST_SIZE) state_n = WAIT;
      end
      WAIT:   if (cnt == LAST_LAT) state_n = CHECK;
      CHECK: begin
        compare_valid = 1'b1;
        state_n       = (pat == LAST_PAT) ? DONE : LOAD_W;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    weight_flat    = weight_load ? {SYSTOLIC_SIZE{rom_weight}} : '0;
    act_flat       = act_valid ? {SYSTOLIC_SIZE{rom_act}} : '0;
    correct_answer = compare_valid ? rom_golden : '0;
    fault_map_n    = fault_map | compared_results;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pat       <= '0;
      fault_map <= '0;
      pass      <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= (state_n != state || state == IDLE) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: begin
          pat <= '0;
          if (start) begin
            fault_map <= '0;
            pass      <= 1'b0;
          end
        end
        CHECK: begin
          fault_map <= fault_map_n;
          // Resolve pass from the final capture so it is already valid while done is high.
          if (pat == LAST_PAT) pass <= (fault_map_n == '0);
          else                 pat  <= pat + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bist_pattern_gen.sv
// Scoreboarded bench for bist_pattern_gen: directed tests with hand-computed
// golden sums, fault maps and strobe timing.
module tb_bist_pattern_gen;

  localparam int S        = 8;
  localparam int PSW      = 19;
  localparam int NP       = 4;
  localparam int L        = 16;
  localparam int PER      = 2 * S + L + 1;
  localparam int DONE_REL = 1 + NP * PER;
  localparam int EW       = 16 + PSW + S;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [S-1:0]     compared_results = '0;
  logic             weight_load, act_valid, compare_valid, busy, done, pass;
  logic [8*S-1:0]   weight_flat, act_flat;
  logic [PSW-1:0]   correct_answer;
  logic [S-1:0]     fault_map;

  bist_pattern_gen #(
    .SYSTOLIC_SIZE(S), .WEIGHT_WIDTH(8), .ACTIVATION_WIDTH(8),
    .PARTIAL_SUM_WIDTH(PSW), .NUM_PATTERNS(NP), .ARRAY_LATENCY(L)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .weight_load(weight_load), .weight_flat(weight_flat),
    .act_valid(act_valid), .act_flat(act_flat),
    .correct_answer(correct_answer), .compare_valid(compare_valid),
    .compared_results(compared_results), .fault_map(fault_map),
    .busy(busy), .done(done), .pass(pass)
  );

  // Clock and cycle count (cyc = number of rising edges so far)
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Hand-computed reference tables
  logic [7:0]     pat_w [4] = '{8'hFF, 8'h55, 8'h0F, 8'h01};
  logic [7:0]     pat_a [4] = '{8'hFF, 8'hAA, 8'hF0, 8'h01};
  logic [PSW-1:0] gold  [4] = '{19'h7F008, 19'h1C390, 19'h07080, 19'h00008};
  logic [S-1:0]   fm_tab [3][4] = '{'{8'h00, 8'h00, 8'h00, 8'h00},
                                    '{8'h00, 8'h04, 8'h04, 8'h04},
                                    '{8'hFF, 8'hFF, 8'hFF, 8'hFF}};

  // Scoreboard state
  logic [EW-1:0] exp_q[$];
  int            done_q[$];
  int            t_start = 0;
  bit            mon_en = 1'b0;
  logic [S-1:0]  exp_fm = '0;
  logic [S-1:0]  exp_fm_final = '0;
  bit            exp_pass = 1'b0;
  int            n_vec = 0;
  int            n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_weight_load"}, 64'(weight_load), 0);
    chk({tag, "_weight_flat"}, weight_flat, 0);
    chk({tag, "_act_valid"}, 64'(act_valid), 0);
    chk({tag, "_act_flat"}, act_flat, 0);
    chk({tag, "_compare_valid"}, 64'(compare_valid), 0);
    chk({tag, "_correct_answer"}, 64'(correct_answer), 0);
  endtask

  function automatic logic [S-1:0] cr_for(input int mode, input int r);
    if (mode == 1) return (r == 2 * PER) ? 8'h04 : 8'h00;
    if (mode == 2) return 8'hFF;
    return 8'h00;
  endfunction

  // Monitor: samples 1 time unit after each rising edge
  initial begin
    forever begin
      int rel, off, p;
      logic [EW-1:0] e;
      @(posedge clk);
      #1;
      rel = cyc - t_start + 1;
      if (!mon_en) begin
        chk_quiet("idle");
        chk("idle_done", 64'(done), 0);
        chk("idle_fault_map", 64'(fault_map), 0);
        chk("idle_pass", 64'(pass), 0);
      end else if (rel >= 1 && rel <= DONE_REL) begin
        off = (rel - 1) % PER;
        p   = (rel - 1) / PER;
        chk("busy", 64'(busy), 1);
        if (rel < DONE_REL && off < S) begin
          chk("weight_load", 64'(weight_load), 1);
          chk("weight_flat", weight_flat, {S{pat_w[p]}});
        end else begin
          chk("weight_load", 64'(weight_load), 0);
          chk("weight_flat", weight_flat, 0);
        end
        if (rel < DONE_REL && off >= S && off < 2 * S) begin
          chk("act_valid", 64'(act_valid), 1);
          chk("act_flat", act_flat, {S{pat_a[p]}});
        end else begin
          chk("act_valid", 64'(act_valid), 0);
          chk("act_flat", act_flat, 0);
        end
        chk("fault_map", 64'(fault_map), 64'(exp_fm));
        if (rel < DONE_REL) chk("pass_during_test", 64'(pass), 0);
        if (!compare_valid) chk("correct_answer_idle", 64'(correct_answer), 0);
      end else begin
        chk_quiet("after");
        chk("final_fault_map", 64'(fault_map), 64'(exp_fm_final));
        chk("final_pass", 64'(pass), 64'(exp_pass));
      end
      if (compare_valid) begin
        if (exp_q.size() == 0) chk("unexpected_compare_valid", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("check_cycle", 64'(rel), 64'(e[EW-1 -: 16]));
          chk("correct_answer", 64'(correct_answer), 64'(e[S +: PSW]));
          exp_fm = e[S-1:0];
        end
      end
      if (done) begin
        if (done_q.size() == 0) chk("unexpected_done", 1, 0);
        else chk("done_cycle", 64'(rel), 64'(done_q.pop_front()));
      end
    end
  end

  // Driver: one start, then per-cycle comparator results, extra start pulses, optional reset
  task automatic run_test(input int mode, input bit pulses, input int abort_rel);
    bit aborted;
    aborted = 1'b0;
    @(negedge clk);
    start            = 1'b1;
    compared_results = cr_for(mode, 0);
    t_start          = cyc + 1;
    mon_en           = 1'b1;
    exp_fm           = '0;
    exp_fm_final     = fm_tab[mode][NP-1];
    exp_pass         = (fm_tab[mode][NP-1] == '0);
    for (int i = 0; i < NP; i++)
      exp_q.push_back({16'(PER * (i + 1)), gold[i], fm_tab[mode][i]});
    done_q.push_back(DONE_REL);
    for (int r = 1; r <= DONE_REL + 6 && !aborted; r++) begin
      @(negedge clk);
      start            = pulses && (r == 5 || r == 50 || r == DONE_REL);
      compared_results = cr_for(mode, r);
      if (r == abort_rel) begin
        rst = 1'b1;
        #1;
        chk_quiet("reset");
        chk("reset_done", 64'(done), 0);
        chk("reset_fault_map", 64'(fault_map), 0);
        chk("reset_pass", 64'(pass), 0);
        mon_en = 1'b0;
        exp_q.delete();
        done_q.delete();
        start            = 1'b0;
        compared_results = '0;
        @(negedge clk);
        rst     = 1'b0;
        aborted = 1'b1;
      end
    end
    start = 1'b0;
    chk("leftover_checks", 64'(exp_q.size()), 0);
    chk("leftover_done", 64'(done_q.size()), 0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run_test(0, 1'b0, 0);   // clean run: pass
    run_test(1, 1'b0, 0);   // column 2 fails in second CHECK only
    run_test(2, 1'b0, 0);   // all columns fail, results held high throughout
    run_test(0, 1'b1, 0);   // restart clears map; start pulses while busy ignored
    run_test(2, 1'b0, 55);  // reset during WAIT of p1
    run_test(1, 1'b0, 0);   // rerun after reset begins at p0
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
